eth_frame_tx: RTL and testbench
===============================

// Module: eth_frame_tx
// PURPOSE
// - Parametrised 10BASE-T Manchester frame transmitter; it succeeds the fixed-ROM sender.
// - Host writes payload into an internal byte buffer, sets frame_len and pulses transmit.
// - Block emits preamble+SFD, payload LSB-first, optional FCS, TP_IDL; sends NLPs when idle.
// - Sits between the host/packet builder and the TP line driver (eth_data_s, Tx_w enable).
// PARAMETERS
// - DEPTH        128     payload buffer bytes; AW = $clog2(DEPTH)
// - TP_IDLE_CYC  6       clk cycles line held high after last bit (TP_IDL)
// - NLP_PERIOD   320000  clk cycles between link pulses (16 ms at 20 MHz clk)
// - NLP_WIDTH    2       clk cycles per link pulse (100 ns)
// PORTS
// - clk         in   1      20 MHz; one Manchester half-bit per cycle
// - resetn      in   1      async active-low reset
// - wr_en       in   1      buffer write strobe
// - wr_addr     in   AW     buffer byte address
// - wr_data     in   8      buffer byte
// - frame_len   in   AW+1   payload byte count, sampled with transmit
// - transmit    in   1      start request (pulse or level)
// - busy        out  1      high whenever state != IDLE_s
// - done        out  1      1-cycle pulse on last TP_IDL cycle
// - wr_err      out  1      1-cycle pulse: write dropped because busy
// - eth_data_s  out  1      line data
// - Tx_w        out  1      line driver enable
// BEHAVIOUR
// - Reset: state=IDLE_s; busy, done, wr_err, eth_data_s, Tx_w = 0; NLP timer = 0; pending = 0.
// - One clock, async active-low reset (resetn); all state on posedge clk / negedge resetn.
// - Encoding: eth_data_s = ~(half ^ bit) while sending; half 0 then 1, so 1 -> low,high.
// - Bits leave LSB first; each bit takes 2 cycles, each byte 16 cycles.
// - States: IDLE_s -> PRE_s (7x 0x55 + 0xD5, 128 cyc) -> DATA_s (16*len cyc).
// - DATA_s -> [FCS_s, 64 cyc] -> TPIDLE_s (TP_IDLE_CYC cyc) -> IDLE_s.
// - Latency: transmit seen high in IDLE_s -> next cycle state=PRE_s, Tx_w=1, first half-bit driven.
// - Frame lengths: frame_len latched at start; frame_len > DEPTH clamps to DEPTH.
// - frame_len == 0 skips DATA_s.
// - Buffer fetch: next byte registered on the cycle of the last half-bit of the current byte.
// - No gap between bytes at the line.
// - TPIDLE_s: Tx_w=1, eth_data_s=1; done pulses on its final cycle.
// - Writes: wr_en in IDLE_s writes mem[wr_addr]; while busy the write is dropped, wr_err=1.
// - transmit while busy is ignored; no queueing.
// - NLP: timer runs only in IDLE_s; at NLP_PERIOD it drives eth_data_s=Tx_w=1 for NLP_WIDTH cycles.
// - The NLP timer restarts from 0 when a frame ends.
// - transmit during an NLP pulse sets pending; frame starts the cycle after the pulse ends.
// - Reset mid-frame: line drops to 0 and Tx_w=0 immediately (async); buffer contents undefined.
// CONFIGURATION
// - ETH_FCS_GEN_EN defined: CRC-32 runs over payload bits.
//   - Reflected poly 0xEDB88320, init 0xFFFFFFFF, updated each bit's 2nd half.
//   - FCS_s sends ~crc LSB first (low byte first).
// - ETH_FCS_GEN_EN undefined: no CRC logic, DATA_s -> TPIDLE_s directly.
//   - Host must place FCS in the buffer itself.
// STRUCTURE
// - eth_pkg: state enum (IDLE_s, PRE_s, DATA_s, FCS_s, TPIDLE_s), PREAMBLE_BYTE=8'h55.
// - eth_pkg also holds SFD_BYTE=8'hD5, PRE_BYTES=7, CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF.
// - Sub-module eth_crc32: bit-serial CRC (clk, resetn, init, en, bit_in -> crc[31:0]).
//   - Instantiated only under ETH_FCS_GEN_EN.
// TESTING
// - Preamble/SFD: frame_len=1, mem[0]=0xA5, no FCS.
//   - Expect 128 cyc alternating pattern decoding to 7x55,D5, then A5.
//   - Then 6 cyc high; Tx_w high 150 cyc; done once.
// - FCS: mem="123456789", frame_len=9, ETH_FCS_GEN_EN.
//   - Expect decoded FCS bytes 26,39,F4,CB; Tx_w high 128+144+64+6 cyc.
// - Clamp/wrap: DEPTH=128, frame_len=200.
//   - Expect exactly 128 payload bytes sent, mem[127] last; addr wraps to 0 afterward.
// - Busy protection: wr_en and transmit pulsed mid-DATA_s.
//   - Expect wr_err pulse, mem unchanged, no second frame.
// - NLP: NLP_PERIOD=100; idle.
//   - Expect 2-cycle high pulses every 100 cyc.
//   - transmit during pulse -> frame starts 1 cyc after pulse ends.
// - Reset mid-frame: drop resetn in DATA_s.
//   - Expect eth_data_s=Tx_w=busy=0 same cycle; new transmit after release sends a full frame.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the 10BASE-T Manchester frame transmitter.
// Optional CRC-32 FCS generation is enabled by defining ETH_FCS_GEN_EN.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE_s,
    PRE_s,
    DATA_s,
    FCS_s,
    TPIDLE_s
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned PRE_BYTES     = 7;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

endpackage

// File: rtl/eth_crc32.sv
// Bit-serial reflected CRC-32 used for the Ethernet FCS.
// Only instantiated when ETH_FCS_GEN_EN is defined.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = (crc_q >> 1) ^ ((crc_q[0] ^ bit_in) ? CRC_POLY : 32'h0);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/eth_frame_tx.sv
// 10BASE-T Manchester frame transmitter: preamble/SFD, buffered payload, optional FCS,
// TP_IDL and normal link pulses while idle. Define ETH_FCS_GEN_EN to append a generated FCS.
module eth_frame_tx
  import eth_pkg::*;
#(
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned TP_IDLE_CYC = 6,
  parameter int unsigned NLP_PERIOD  = 320000,
  parameter int unsigned NLP_WIDTH   = 2,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW:0]   frame_len,
  input  logic          transmit,
  output logic          busy,
  output logic          done,
  output logic          wr_err,
  output logic          eth_data_s,
  output logic          Tx_w
);

  localparam logic [AW:0] DepthLen = (AW+1)'(DEPTH);
  localparam logic [7:0]  PreLast  = 8'd127;  // 8 bytes x 16 half-bits
  localparam logic [7:0]  TpLast   = 8'(TP_IDLE_CYC - 1);
  localparam logic [31:0] NlpLast  = 32'(NLP_PERIOD - 1);
`ifdef ETH_FCS_GEN_EN
  localparam state_e AfterData = FCS_s;
`else
  localparam state_e AfterData = TPIDLE_s;
`endif

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   left_q, left_d;
  logic [31:0]   nlp_timer_q, nlp_timer_d;
  logic [7:0]    pulse_cnt_q, pulse_cnt_d;
  logic          pending_q, pending_d;
  logic          start;
  logic [7:0]    pre_cur;
  logic [7:0]    mem_q [DEPTH];

`ifdef ETH_FCS_GEN_EN
  logic [31:0] crc;
  logic [31:0] fcs;

  eth_crc32 u_crc (
    .clk    (clk),
    .resetn (resetn),
    .init   (start),
    .en     (state_q == DATA_s && cnt_q[0]),
    .bit_in (byte_q[cnt_q[3:1]]),
    .crc    (crc)
  );

  assign fcs = ~crc;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    addr_d      = addr_q;
    left_d      = left_q;
    nlp_timer_d = nlp_timer_q;
    pulse_cnt_d = pulse_cnt_q;
    pending_d   = pending_q;
    start       = 1'b0;
    unique case (state_q)
      IDLE_s: begin
        nlp_timer_d = (nlp_timer_q == NlpLast) ? '0 : nlp_timer_q + 32'd1;
        if (pulse_cnt_q != '0) begin
          // A request during a link pulse is held and launched right after it.
          pulse_cnt_d = pulse_cnt_q - 8'd1;
          pending_d   = pending_q | transmit;
          start       = (pulse_cnt_q == 8'd1) && (pending_q || transmit);
        end else if (transmit) begin
          start = 1'b1;
        end else if (nlp_timer_q == NlpLast) begin
          pulse_cnt_d = 8'(NLP_WIDTH);
        end
        if (start) begin
          state_d     = PRE_s;
          cnt_d       = '0;
          addr_d      = '0;
          pending_d   = 1'b0;
          pulse_cnt_d = '0;
          nlp_timer_d = '0;
          left_d      = (frame_len > DepthLen) ? DepthLen : frame_len;
        end
      end
      PRE_s: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == PreLast) begin
          cnt_d = '0;
          if (left_q == '0) begin
            state_d = AfterData;
          end else begin
            state_d = DATA_s;
            byte_d  = mem_q[addr_q];
            addr_d  = addr_q + AW'(1);
          end
        end
      end
      DATA_s: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd15) begin
          cnt_d  = '0;
          left_d = left_q - (AW+1)'(1);
          if (left_q == (AW+1)'(1)) begin
            state_d = AfterData;
          end else begin
            byte_d = mem_q[addr_q];
            addr_d = addr_q + AW'(1);
          end
        end
      end
      FCS_s: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd63) begin
          cnt_d   = '0;
          state_d = TPIDLE_s;
        end
      end
      TPIDLE_s: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == TpLast) begin
          cnt_d       = '0;
          state_d     = IDLE_s;
          nlp_timer_d = '0;
        end
      end
      default: state_d = IDLE_s;
    endcase
  end

  always_comb begin
    pre_cur    = (cnt_q[6:4] == 3'(PRE_BYTES)) ? SFD_BYTE : PREAMBLE_BYTE;
    busy       = (state_q != IDLE_s);
    Tx_w       = busy;
    eth_data_s = 1'b0;
    unique case (state_q)
      IDLE_s: begin
        Tx_w       = (pulse_cnt_q != '0);
        eth_data_s = (pulse_cnt_q != '0);
      end
      PRE_s:    eth_data_s = ~(cnt_q[0] ^ pre_cur[cnt_q[3:1]]);
      DATA_s:   eth_data_s = ~(cnt_q[0] ^ byte_q[cnt_q[3:1]]);
`ifdef ETH_FCS_GEN_EN
      FCS_s:    eth_data_s = ~(cnt_q[0] ^ fcs[cnt_q[5:1]]);
`else
      FCS_s:    eth_data_s = 1'b0;
`endif
      TPIDLE_s: eth_data_s = 1'b1;
      default:  eth_data_s = 1'b0;
    endcase
  end

  assign done   = (state_q == TPIDLE_s) && (cnt_q == TpLast);
  assign wr_err = wr_en & busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE_s;
      cnt_q       <= '0;
      byte_q      <= '0;
      addr_q      <= '0;
      left_q      <= '0;
      nlp_timer_q <= '0;
      pulse_cnt_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      addr_q      <= addr_d;
      left_q      <= left_d;
      nlp_timer_q <= nlp_timer_d;
      pulse_cnt_q <= pulse_cnt_d;
      pending_q   <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Scoreboard bench for eth_frame_tx: stimulus queues expected frames, a line monitor decodes
// Manchester output and checks frames and idle link pulses against a byte-level model.
`timescale 1ns/1ps
module tb_eth_frame_tx;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 7;
  localparam int unsigned TP    = 6;
  localparam int unsigned NLP_P = 100;
  localparam int unsigned NLP_W = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic [AW:0]   frame_len = '0;
  logic          transmit = 1'b0;
  logic          busy, done, wr_err, eth_data_s, Tx_w;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_mem [DEPTH];
  logic [7:0] exp_bytes [$];
  int         exp_len [$];

  eth_frame_tx #(
    .DEPTH       (DEPTH),
    .TP_IDLE_CYC (TP),
    .NLP_PERIOD  (NLP_P),
    .NLP_WIDTH   (NLP_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_len  (frame_len),
    .transmit   (transmit),
    .busy       (busy),
    .done       (done),
    .wr_err     (wr_err),
    .eth_data_s (eth_data_s),
    .Tx_w       (Tx_w)
  );

  always #25 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  task automatic push_frame(input int n);
    int          m;
    logic [31:0] c;
    m = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    for (int i = 0; i < m; i++) begin
      exp_bytes.push_back(model_mem[i]);
      c = crc_upd(c, model_mem[i]);
    end
`ifdef ETH_FCS_GEN_EN
    c = ~c;
    for (int k = 0; k < 4; k++) exp_bytes.push_back(c[8*k +: 8]);
    exp_len.push_back(8 + m + 4);
`else
    exp_len.push_back(8 + m);
`endif
  endtask

  // ---------------- monitor ----------------
  logic cap [$];
  int   tx_gaps = 0;
  int   done_cnt = 0;
  logic done_last = 1'b0;

  task automatic finish_frame();
    int         nb;
    int         bad;
    int         ones;
    logic [7:0] b;
    logic [7:0] e;
    if (exp_len.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got %0d busy cycles, expected no frame", cap.size());
    end else begin
      nb = exp_len.pop_front();
      bad = 0;
      check("frame_cycles", 64'(cap.size()), 64'(nb * 16 + int'(TP)));
      check("txw_gaps", 64'(tx_gaps), 64'd0);
      check("done_count", 64'(done_cnt), 64'd1);
      check("done_on_last", 64'(done_last), 64'd1);
      for (int j = 0; j < nb; j++) begin
        e = exp_bytes.pop_front();
        b = 8'h00;
        if (cap.size() >= (j + 1) * 16) begin
          for (int k = 0; k < 8; k++) begin
            if (cap[j*16 + 2*k] === cap[j*16 + 2*k + 1]) bad++;
            b[k] = cap[j*16 + 2*k + 1];
          end
        end
        check($sformatf("byte%0d", j), 64'(b), 64'(e));
      end
      ones = 0;
      if (cap.size() >= nb * 16 + int'(TP)) begin
        for (int k = 0; k < int'(TP); k++) if (cap[nb*16 + k] === 1'b1) ones++;
      end
      check("tp_idl_high", 64'(ones), 64'(TP));
      check("manchester", 64'(bad), 64'd0);
    end
    cap.delete();
    tx_gaps   = 0;
    done_cnt  = 0;
    done_last = 1'b0;
  endtask

  initial begin : monitor
    int   idle_i;
    bit   in_frame;
    logic p;
    idle_i   = 0;
    in_frame = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        cap.delete();
        tx_gaps   = 0;
        done_cnt  = 0;
        done_last = 1'b0;
        in_frame  = 0;
        idle_i    = 0;
      end else if (busy) begin
        in_frame = 1;
        cap.push_back(eth_data_s);
        if (Tx_w !== 1'b1) tx_gaps++;
        if (done === 1'b1) done_cnt++;
        done_last = done;
      end else begin
        if (in_frame) begin
          finish_frame();
          in_frame = 0;
          idle_i   = 0;
        end
        p = (idle_i >= int'(NLP_P)) && ((idle_i % int'(NLP_P)) < int'(NLP_W));
        check("idle_line", {61'd0, Tx_w, eth_data_s, done}, {61'd0, p, p, 1'b0});
        idle_i++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    #1;
    check("wr_err_idle", 64'(wr_err), 64'd0);
    tick();
    wr_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (busy && k < bound) begin
      tick();
      k++;
    end
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic wait_busy(input int bound);
    int k;
    k = 0;
    while (!busy && k < bound) begin
      tick();
      k++;
    end
    check("frame_started", 64'(busy), 64'd1);
  endtask

  task automatic send(input int n);
    frame_len = (AW+1)'(n);
    push_frame(n);
    transmit = 1'b1;
    tick();
    transmit = 1'b0;
    wait_busy(4);
    wait_idle(3000);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) write_byte(i, 8'($urandom));
  endtask

  initial begin : watchdog
    #(50 * 90000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    int  k;
    bit  seen_low;
    string s;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {59'd0, busy, done, wr_err, eth_data_s, Tx_w}, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Preamble/SFD with a single byte, plus start latency.
    write_byte(0, 8'hA5);
    k = 0;
    while (Tx_w && k < 10) begin
      tick();
      k++;
    end
    frame_len = (AW+1)'(1);
    push_frame(1);
    transmit = 1'b1;
    tick();
    transmit = 1'b0;
    check("start_latency", {61'd0, busy, Tx_w, eth_data_s}, 64'b110);
    wait_idle(3000);

    // Random payloads including zero length.
    for (int f = 0; f < 5; f++) begin
      k = (f == 0) ? 0 : int'($urandom_range(1, 24));
      fill_random(k);
      send(k);
    end

    // Oversized length clamps to the buffer depth.
    fill_random(DEPTH);
    send(200);

`ifdef ETH_FCS_GEN_EN
    s = "123456789";
    for (int i = 0; i < 9; i++) write_byte(i, s[i]);
    send(9);
`endif

    // Writes and requests while busy are dropped.
    fill_random(4);
    frame_len = (AW+1)'(4);
    push_frame(4);
    transmit = 1'b1;
    tick();
    transmit = 1'b0;
    wait_busy(4);
    repeat (150) tick();
    wr_en    = 1'b1;
    wr_addr  = '0;
    wr_data  = ~model_mem[0];
    transmit = 1'b1;
    #1;
    check("wr_err_busy", {62'd0, wr_err, busy}, 64'b11);
    tick();
    wr_en    = 1'b0;
    transmit = 1'b0;
    wait_idle(3000);
    repeat (250) tick();
    check("no_second_frame", 64'(busy), 64'd0);
    send(1);

    // Request during a link pulse starts right after the pulse.
    fill_random(2);
    frame_len = (AW+1)'(2);
    k = 0;
    seen_low = 0;
    while (!(seen_low && Tx_w && !busy) && k < 300) begin
      if (!Tx_w) seen_low = 1;
      tick();
      k++;
    end
    check("nlp_found", {62'd0, Tx_w, busy}, 64'b10);
    push_frame(2);
    transmit = 1'b1;
    tick();
    transmit = 1'b0;
    check("pend_pulse_tail", {62'd0, Tx_w, busy}, 64'b10);
    tick();
    check("pend_start", 64'(busy), 64'd1);
    wait_idle(3000);

    // Asynchronous reset in the middle of the payload.
    fill_random(10);
    frame_len = (AW+1)'(10);
    transmit = 1'b1;
    tick();
    transmit = 1'b0;
    repeat (140) tick();
    check("mid_frame_busy", 64'(busy), 64'd1);
    #5;
    resetn = 1'b0;
    #1;
    check("async_reset_outs", {61'd0, eth_data_s, Tx_w, busy}, 64'd0);
    repeat (2) tick();
    resetn = 1'b1;
    fill_random(3);
    send(3);

    k = 0;
    while (exp_len.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    check("expected_drained", 64'(exp_len.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
